// File: rtl/seven_seg_scheduler.sv
// seven_seg_scheduler: shares one seven-segment display among ISO, shutter, focal and brightness,
// with change pre-emption and a debounced home-channel button. AUTO_CYCLE_EN adds home auto-cycling.
module seven_seg_scheduler #(
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CYCLE_CYCLES    = 150_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] iso_value,
    input  logic [3:0] shutter_value,
    input  logic [3:0] focal_value,
    input  logic [2:0] bright_value,
    input  logic       btn_next,
    input  logic       auto_en,
    output logic [3:0] display_value,
    output logic [1:0] display_select,
    output logic       override_active
);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {HOME, OVER} state_t;

    state_t            state;
    logic [3:0]        snap_iso, snap_shutter, snap_focal;
    logic [3:0]        prev_iso, prev_shutter, prev_focal;
    logic [2:0]        snap_bright, prev_bright;
    logic              snap_vld, primed;
    logic [3:0]        chg;
    logic              btn_s1, btn_s2, btn_level, press;
    logic [DB_W-1:0]   db_cnt;
    logic [1:0]        home_sel, ovr_ch, sel, next_ch;
    logic [HOLD_W-1:0] hold_tmr;
    logic [3:0]        pending, serving, pend_all;

`ifdef AUTO_CYCLE_EN
    localparam int CYC_W = $clog2(CYCLE_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLE_CYCLES - 1);
    logic [CYC_W-1:0] cyc_tmr;
`else
    localparam int unused_cycle_cycles = CYCLE_CYCLES;
    logic unused_auto_en;
    assign unused_auto_en = auto_en;
`endif

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0]) return 2'd0;
        if (m[1]) return 2'd1;
        if (m[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    // snap_vld then primed: prev only holds a real sample two cycles after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_iso     <= '0;
            snap_shutter <= '0;
            snap_focal   <= '0;
            snap_bright  <= '0;
            prev_iso     <= '0;
            prev_shutter <= '0;
            prev_focal   <= '0;
            prev_bright  <= '0;
            snap_vld     <= 1'b0;
            primed       <= 1'b0;
        end else begin
            snap_iso     <= iso_value;
            snap_shutter <= shutter_value;
            snap_focal   <= focal_value;
            snap_bright  <= bright_value;
            prev_iso     <= snap_iso;
            prev_shutter <= snap_shutter;
            prev_focal   <= snap_focal;
            prev_bright  <= snap_bright;
            snap_vld     <= 1'b1;
            primed       <= snap_vld;
        end
    end

    always_comb begin
        chg = 4'b0000;
        if (primed) begin
            chg[0] = snap_iso     != prev_iso;
            chg[1] = snap_shutter != prev_shutter;
            chg[2] = snap_focal   != prev_focal;
            chg[3] = snap_bright  != prev_bright;
        end
    end

    assign serving  = (state == OVER) ? onehot(ovr_ch) : 4'b0000;
    assign pend_all = pending | (chg & ~serving);
    assign next_ch  = lowest(pend_all);
    assign sel      = (state == OVER) ? ovr_ch : home_sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_level <= 1'b0;
            press     <= 1'b0;
            db_cnt    <= '0;
        end else begin
            btn_s1 <= btn_next;
            btn_s2 <= btn_s1;
            press  <= 1'b0;
            if (btn_s2 == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt    <= '0;
                btn_level <= btn_s2;
                press     <= btn_s2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= HOME;
            home_sel        <= 2'd0;
            ovr_ch          <= 2'd0;
            hold_tmr        <= '0;
            pending         <= 4'b0000;
            override_active <= 1'b0;
`ifdef AUTO_CYCLE_EN
            cyc_tmr         <= '0;
`endif
        end else begin
            case (state)
                HOME: begin
                    if (press) begin
                        home_sel <= home_sel + 2'd1;
`ifdef AUTO_CYCLE_EN
                    end else if (auto_en && cyc_tmr == CYC_LAST) begin
                        home_sel <= home_sel + 2'd1;
`endif
                    end
`ifdef AUTO_CYCLE_EN
                    if (press || !auto_en || cyc_tmr == CYC_LAST) cyc_tmr <= '0;
                    else                                          cyc_tmr <= cyc_tmr + 1'b1;
`endif
                    if (pend_all != 4'b0000) begin
                        state           <= OVER;
                        ovr_ch          <= next_ch;
                        hold_tmr        <= HOLD_LOAD;
                        pending         <= pend_all & ~onehot(next_ch);
                        override_active <= 1'b1;
                    end else begin
                        pending <= pend_all;
                    end
                end
                OVER: begin
                    if (press) begin
                        // press aborts the whole override queue and is not a home advance
                        state           <= HOME;
                        pending         <= 4'b0000;
                        override_active <= 1'b0;
`ifdef AUTO_CYCLE_EN
                        cyc_tmr         <= '0;
`endif
                    end else if (chg[ovr_ch]) begin
                        hold_tmr <= HOLD_LOAD;
                        pending  <= pend_all;
                    end else if (hold_tmr == '0) begin
                        if (pend_all != 4'b0000) begin
                            ovr_ch   <= next_ch;
                            hold_tmr <= HOLD_LOAD;
                            pending  <= pend_all & ~onehot(next_ch);
                        end else begin
                            state           <= HOME;
                            override_active <= 1'b0;
                            pending         <= pend_all;
`ifdef AUTO_CYCLE_EN
                            cyc_tmr         <= '0;
`endif
                        end
                    end else begin
                        hold_tmr <= hold_tmr - 1'b1;
                        pending  <= pend_all;
                    end
                end
                default: state <= HOME;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            display_select <= 2'd0;
            display_value  <= 4'd0;
        end else begin
            display_select <= sel;
            case (sel)
                2'd0:    display_value <= snap_iso;
                2'd1:    display_value <= snap_shutter;
                2'd2:    display_value <= snap_focal;
                default: display_value <= {1'b0, snap_bright};
            endcase
        end
    end
endmodule
